// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte handshake between a producer and uart_tx_engine
//   tx_data  [7:0] byte offered by the producer, sampled only on handshake
//   tx_valid       producer has a byte
//   tx_ready       engine accepts a byte this cycle
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: 8N1/8N2 UART transmitter fed from a valid/ready byte interface
//   clk       30 MHz system clock
//   rst_n     asynchronous active-low reset; forces uart_tx high at once
//   tx_if     slave side of uart_tx_if (tx_data, tx_valid, tx_ready)
//   uart_cts  active-low clear-to-send, only used when UART_TX_CTS_EN is defined
//   uart_tx   registered serial line, idle high
//   busy      high from the accept edge until the last stop bit ends
// Optional feature: define UART_TX_CTS_EN to gate accepts with a synchronized uart_cts.
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 260,
  parameter int STOP_BITS    = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave tx_if,
  input  logic     uart_cts,
  output logic     uart_tx,
  output logic     busy
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          cts_clear;
  logic          accept;
  logic          bit_end;
`ifdef UART_TX_CTS_EN
  // Two-flop synchronizer; resets to "not clear" so nothing leaves before CTS is seen.
  logic cts_meta_q, cts_sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= uart_cts;
      cts_sync_q <= cts_meta_q;
    end
  assign cts_clear = ~cts_sync_q;
`else
  logic unused_cts;
  assign unused_cts = uart_cts;
  assign cts_clear  = 1'b1;
`endif
  assign tx_if.tx_ready = (state_q == IDLE) & rst_n & cts_clear;
  assign accept         = tx_if.tx_valid & tx_if.tx_ready;
  assign bit_end        = baud_q == BAUD_LAST;
  assign uart_tx        = tx_q;
  assign busy           = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;
    case (state_q)
      IDLE:
        if (accept) begin
          state_d = START;
          shift_d = tx_if.tx_data;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
        end
      START:
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      DATA:
        // shift_q[0] is on the line; the next bit is already waiting in shift_q[1].
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          tx_d    = shift_q[1];
          if (bit_q == 3'd7) begin
            state_d = STOP;
            bit_d   = '0;
            tx_d    = 1'b1;
          end
        end
      STOP:
        // bit_q counts stop bits here.
        if (bit_end) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
            bit_d   = '0;
          end
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: self-checking bench for uart_tx_engine
module tb_uart_tx_engine;
  localparam int C  = 260;
  localparam int C2 = 4;
  typedef struct {
    logic [7:0] data;
    logic [9:0] lv;
    logic       chg;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cts = 1'b0;
  logic tx, busy, tx2, busy2;
  int checks = 0;
  int failures = 0;
  int nacc, lo, hi, nb, bad, nfr;
  logic exp_idle, e_tx;
  logic exp_q[$];
  vec_t vec[5];
  uart_tx_if bus();
  uart_tx_if bus2();
  uart_tx_engine dut (
    .clk(clk), .rst_n(rst_n), .tx_if(bus.slave), .uart_cts(cts), .uart_tx(tx), .busy(busy)
  );
  uart_tx_engine #(.CLKS_PER_BIT(C2), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_if(bus2.slave), .uart_cts(1'b0), .uart_tx(tx2), .busy(busy2)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Called at a negedge; holds tx_valid until the engine is ready, returns at the
  // negedge right after the accept edge (first start-bit sample).
  task automatic accept_byte(input logic [7:0] b);
    int i = 0;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    while (bus.tx_ready !== 1'b1 && i < 6000) begin
      @(negedge clk);
      i++;
    end
    check("ready wait", {31'b0, bus.tx_ready}, 1);
    @(negedge clk);
  endtask
  // Checks one 8N1 frame sample by sample; lv lists line levels first-to-last.
  task automatic run_frame(input string nm, input logic [9:0] lv, input logic chg, input logic rdy_end);
    int nbad = 0;
    int nbusy = 0;
    for (int k = 0; k < 10 * C; k++) begin
      if (k > 0) @(negedge clk);
      if (chg && k == 5 * C) bus.tx_data = ~bus.tx_data;
      if (tx !== lv[9 - k / C] || bus.tx_ready !== 1'b0) nbad++;
      if (busy === 1'b1) nbusy++;
    end
    check({nm, " levels"}, nbad, 0);
    check({nm, " busy cycles"}, nbusy, 10 * C);
    @(negedge clk);
    check({nm, " idle line"}, {31'b0, tx}, 1);
    check({nm, " busy end"}, {31'b0, busy}, 0);
    check({nm, " ready end"}, {31'b0, bus.tx_ready}, {31'b0, rdy_end});
  endtask
  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    vec[0] = '{8'h43, 10'b0110000101, 1'b0};
    vec[1] = '{8'h00, 10'b0000000001, 1'b0};
    vec[2] = '{8'hFF, 10'b0111111111, 1'b0};
    vec[3] = '{8'h0F, 10'b0111100001, 1'b1};
    vec[4] = '{8'h3C, 10'b0001111001, 1'b1};
    bus.tx_valid  = 1'b0;
    bus.tx_data   = 8'h00;
    bus2.tx_valid = 1'b0;
    bus2.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst uart_tx", {31'b0, tx}, 1);
    check("rst ready", {31'b0, bus.tx_ready}, 0);
    check("rst busy", {31'b0, busy}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("ready after rst", {31'b0, bus.tx_ready}, 1);
    foreach (vec[i]) begin
      accept_byte(vec[i].data);
      bus.tx_valid = 1'b0;
      run_frame($sformatf("vec%0d", i), vec[i].lv, vec[i].chg, 1'b1);
    end
    accept_byte(8'h55);
    bus.tx_data = 8'hAA;
    run_frame("b2b 55", 10'b0101010101, 1'b0, 1'b1);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    run_frame("b2b AA", 10'b0010101011, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("b2b no dup", {31'b0, busy}, 0);
    accept_byte(8'hA5);
    bus.tx_valid = 1'b0;
    repeat (4 * C + C / 2) @(negedge clk);
    check("A5 bit3 before rst", {31'b0, tx}, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async rst uart_tx", {31'b0, tx}, 1);
    check("async rst busy", {31'b0, busy}, 0);
    check("async rst ready", {31'b0, bus.tx_ready}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("ready after mid rst", {31'b0, bus.tx_ready}, 1);
    accept_byte(8'h3C);
    bus.tx_valid = 1'b0;
    run_frame("after rst 3C", 10'b0001111001, 1'b0, 1'b1);
`ifdef UART_TX_CTS_EN
    cts = 1'b1;
    repeat (3) @(negedge clk);
    bus.tx_data  = 8'h5A;
    bus.tx_valid = 1'b1;
    nacc = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.tx_ready !== 1'b0 || busy !== 1'b0) nacc++;
    end
    check("cts blocks accept", nacc, 0);
    cts = 1'b0;
    @(negedge clk);
    check("cts latency 1", {31'b0, bus.tx_ready}, 0);
    @(negedge clk);
    check("cts latency 2", {31'b0, bus.tx_ready}, 1);
    @(negedge clk);
    cts = 1'b1;
    bus.tx_data = 8'h11;
    run_frame("cts frame", 10'b0010110101, 1'b0, 1'b0);
    nacc = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) nacc++;
    end
    check("cts holds next", nacc, 0);
    bus.tx_valid = 1'b0;
    cts = 1'b0;
`endif
    bus2.tx_data  = 8'hFF;
    bus2.tx_valid = 1'b1;
    nacc = 0;
    while (bus2.tx_ready !== 1'b1 && nacc < 100) begin
      @(negedge clk);
      nacc++;
    end
    check("8N2 ready wait", {31'b0, bus2.tx_ready}, 1);
    @(negedge clk);
    bus2.tx_valid = 1'b0;
    lo = 0;
    hi = 0;
    nb = 0;
    for (int k = 0; k < 44; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 4 && tx2 === 1'b0) lo++;
      if (k >= 4 && tx2 === 1'b1) hi++;
      if (busy2 === 1'b1) nb++;
    end
    check("8N2 low cycles", lo, 4);
    check("8N2 high cycles", hi, 40);
    check("8N2 busy cycles", nb, 44);
    @(negedge clk);
    check("8N2 busy end", {31'b0, busy2}, 0);
    check("8N2 ready end", {31'b0, bus2.tx_ready}, 1);
    // Random producer against a queue of expected line levels per accepted byte.
    bad = 0;
    nfr = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n > 0) @(negedge clk);
      exp_idle = exp_q.size() == 0;
      e_tx = exp_idle ? 1'b1 : exp_q.pop_front();
      if (tx2 !== e_tx || busy2 !== !exp_idle || bus2.tx_ready !== exp_idle) begin
        if (bad == 0) $display("first random divergence at cycle %0d: tx=%b exp %b", n, tx2, e_tx);
        bad++;
      end
      bus2.tx_valid = ($urandom_range(0, 3) != 0);
      bus2.tx_data  = 8'($urandom);
      if (exp_idle && bus2.tx_valid) begin
        for (int b = 0; b < 11; b++)
          for (int r = 0; r < C2; r++)
            exp_q.push_back(b == 0 ? 1'b0 : (b <= 8 ? bus2.tx_data[b-1] : 1'b1));
        nfr++;
      end
    end
    check("random stream", bad, 0);
    $display("random frames sent: %0d", nfr);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
